wb_coeff_master: RTL and testbench
==================================

WB_COEFF_MASTER -- requirements
Module: wb_coeff_master

Interface
REQ-001 The block SHALL have parameter ADR_W, default 22, meaning the WB address width.
REQ-002 The block SHALL have parameter DAT_W, default 32, meaning the WB data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, meaning cycles to wait for termination before abandoning a cycle.
REQ-004 The block SHALL have parameter MAX_RETRY, default 3, meaning the maximum number of reissues after rty.
REQ-005 The block SHALL have port wb_clk_i, input, 1 bit: the single clock, all logic rising-edge.
REQ-006 The block SHALL have port wb_rst_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have command ports: cmd_valid_i in 1, cmd_ready_o out 1, cmd_adr_i in ADR_W, cmd_dat_i in DAT_W, cmd_we_i in 1 (1 = write).
REQ-008 The block SHALL have response ports: rsp_valid_o out 1, rsp_ready_i in 1, rsp_dat_o out DAT_W (read data), rsp_status_o out 2 (0 OK, 1 ERR, 2 TIMEOUT, 3 RETRY_EXHAUSTED).
REQ-009 The block SHALL have WB initiator ports: wb_cyc_o, wb_stb_o, wb_we_o out 1; wb_adr_o out ADR_W; wb_dat_o out DAT_W; wb_sel_o out DAT_W/8; wb_ack_i, wb_err_i, wb_rty_i in 1; wb_dat_i in DAT_W.
REQ-010 The block SHALL have port busy_o, output, 1 bit: high in every state except IDLE.

Function
REQ-011 States SHALL be IDLE, CYCLE, BACKOFF, RESP.
REQ-012 cmd_ready_o SHALL equal (state == IDLE); a command is accepted on cycle N when cmd_valid_i && cmd_ready_o.
REQ-013 On acceptance adr/dat/we SHALL be registered, retry count cleared, timeout count cleared, and the state SHALL become CYCLE, so wb_cyc_o/wb_stb_o are high from cycle N+1.
REQ-014 In CYCLE wb_cyc_o = wb_stb_o = 1, wb_sel_o all ones, wb_adr_o/wb_dat_o/wb_we_o SHALL hold the registered command unchanged.
REQ-015 Termination SHALL be sampled in CYCLE with priority err > rty > ack.
REQ-016 On ack: rsp_dat_o SHALL capture wb_dat_i (reads; writes capture wb_dat_i too, value don't-care), status 0, state RESP; wb_cyc_o low the next cycle.
REQ-017 On err: status 1, state RESP, no reissue.
REQ-018 On rty with retry count < MAX_RETRY: retry count +1, state BACKOFF (cyc/stb low exactly one cycle), then CYCLE with timeout count cleared.
REQ-019 On rty with retry count == MAX_RETRY: status 3, state RESP.
REQ-020 The timeout counter SHALL increment each CYCLE clock without termination; if it reaches TIMEOUT with no termination that cycle, status 2 and state RESP; termination on the same cycle wins over timeout.
REQ-021 In RESP rsp_valid_o SHALL be 1 and rsp_dat_o/rsp_status_o stable until rsp_ready_i; on rsp_valid_o && rsp_ready_i the state SHALL become IDLE.
REQ-022 A new command SHALL NOT be accepted in the cycle the response is consumed; earliest acceptance is the following cycle.
REQ-023 ack/err/rty outside CYCLE SHALL be ignored.
REQ-024 wb_stb_o SHALL never be high while wb_cyc_o is low.

Reset
REQ-025 While wb_rst_n_i is low: state IDLE, wb_cyc_o/wb_stb_o/wb_we_o 0, wb_adr_o/wb_dat_o 0, wb_sel_o 0, rsp_valid_o 0, rsp_dat_o 0, rsp_status_o 0, busy_o 0, counters 0; cmd_ready_o is 0 during reset and 1 from the first clock after release.
REQ-026 Reset asserted mid-cycle SHALL drop wb_cyc_o immediately (asynchronously) and discard the command with no response.

Structure
REQ-027 A shared package wb_master_pkg SHALL hold the state enum, the 2-bit status enum and status constants.
REQ-028 The block SHALL be one module with no sub-modules; the counters SHALL be inline.

Verification
REQ-029 Write adr 0x000084, dat 0x0000_1234, ack after 2 cycles -> cyc high 3 cycles, wb_we_o 1, rsp status 0, busy_o low after the handshake.
REQ-030 Read adr 0x000004, target returns 0xDEADBEEF with ack -> rsp_dat_o 0xDEADBEEF, status 0.
REQ-031 rty on first and second attempt, ack on third -> exactly one low cyc cycle between attempts, status 0.
REQ-032 rty on every attempt (MAX_RETRY=3) -> 4 attempts total, status 3.
REQ-033 No termination, TIMEOUT=255 -> cyc drops after 255 cycles, status 2; with err and ack asserted together -> status 1.
REQ-034 Reset during CYCLE, then rsp_ready_i held 0 in a later RESP -> cyc low immediately with no response; RESP data held stable until ready.

Source files
------------

// File: rtl/wb_master_pkg.sv
// Shared types for the Wishbone command master: FSM states, response status
// codes and a counter-width helper.
package wb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CYCLE   = 2'd1,
        ST_BACKOFF = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        STATUS_OK        = 2'd0,
        STATUS_ERR       = 2'd1,
        STATUS_TIMEOUT   = 2'd2,
        STATUS_RETRY_EXH = 2'd3
    } status_e;

    localparam logic [1:0] RSP_OK        = 2'd0;
    localparam logic [1:0] RSP_ERR       = 2'd1;
    localparam logic [1:0] RSP_TIMEOUT   = 2'd2;
    localparam logic [1:0] RSP_RETRY_EXH = 2'd3;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/wb_coeff_master.sv
// Single-outstanding Wishbone classic initiator: takes one command, runs the
// bus cycle with retry/backoff and a termination timeout, returns a status.
module wb_coeff_master
    import wb_master_pkg::*;
#(
    parameter int ADR_W     = 22,
    parameter int DAT_W     = 32,
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 3
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,

    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [ADR_W-1:0]   cmd_adr_i,
    input  logic [DAT_W-1:0]   cmd_dat_i,
    input  logic               cmd_we_i,

    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [DAT_W-1:0]   rsp_dat_o,
    output logic [1:0]         rsp_status_o,

    output logic               wb_cyc_o,
    output logic               wb_stb_o,
    output logic               wb_we_o,
    output logic [ADR_W-1:0]   wb_adr_o,
    output logic [DAT_W-1:0]   wb_dat_o,
    output logic [DAT_W/8-1:0] wb_sel_o,
    input  logic               wb_ack_i,
    input  logic               wb_err_i,
    input  logic               wb_rty_i,
    input  logic [DAT_W-1:0]   wb_dat_i,

    output logic               busy_o
);

    localparam int SEL_W = DAT_W / 8;
    localparam int TMO_W = cnt_width(TIMEOUT);
    localparam int RTY_W = cnt_width(MAX_RETRY);

    state_e             state_reg;
    state_e             state_next;

    logic [ADR_W-1:0]   adr_reg;
    logic [DAT_W-1:0]   dat_reg;
    logic               we_reg;
    logic [RTY_W-1:0]   retry_cnt_reg;
    logic [TMO_W-1:0]   tmo_cnt_reg;
    logic [DAT_W-1:0]   rsp_dat_reg;
    status_e            status_reg;
    logic               rst_done_reg;

    logic               cmd_accept;
    logic               tmo_hit;
    logic               retry_left;

    assign cmd_accept = cmd_valid_i && cmd_ready_o;
    // Timeout fires on the cycle the counter would reach TIMEOUT, so the bus
    // stays up for exactly TIMEOUT cycles per attempt.
    assign tmo_hit    = (tmo_cnt_reg == TMO_W'(TIMEOUT - 1));
    assign retry_left = (retry_cnt_reg != RTY_W'(MAX_RETRY));

    // State register; async reset drops cyc/stb immediately.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; termination priority is err > rty > ack > timeout.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_accept) begin
                    state_next = ST_CYCLE;
                end
            end
            ST_CYCLE: begin
                if (wb_err_i) begin
                    state_next = ST_RESP;
                end else if (wb_rty_i) begin
                    state_next = retry_left ? ST_BACKOFF : ST_RESP;
                end else if (wb_ack_i || tmo_hit) begin
                    state_next = ST_RESP;
                end
            end
            ST_BACKOFF: begin
                state_next = ST_CYCLE;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; cmd_ready stays low until the first clock
    // after reset release.
    always_comb begin
        cmd_ready_o = 1'b0;
        busy_o      = 1'b0;
        wb_cyc_o    = 1'b0;
        wb_stb_o    = 1'b0;
        wb_sel_o    = {SEL_W{1'b0}};
        rsp_valid_o = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cmd_ready_o = rst_done_reg;
            end
            ST_CYCLE: begin
                busy_o   = 1'b1;
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_sel_o = {SEL_W{1'b1}};
            end
            ST_BACKOFF: begin
                busy_o = 1'b1;
            end
            ST_RESP: begin
                busy_o      = 1'b1;
                rsp_valid_o = 1'b1;
            end
            default: begin
                busy_o = 1'b1;
            end
        endcase
    end

    assign wb_adr_o     = adr_reg;
    assign wb_dat_o     = dat_reg;
    assign wb_we_o      = we_reg;
    assign rsp_dat_o    = rsp_dat_reg;
    assign rsp_status_o = status_reg;

    // Command capture, retry/timeout counters and response capture.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            adr_reg       <= '0;
            dat_reg       <= '0;
            we_reg        <= 1'b0;
            retry_cnt_reg <= '0;
            tmo_cnt_reg   <= '0;
            rsp_dat_reg   <= '0;
            status_reg    <= STATUS_OK;
            rst_done_reg  <= 1'b0;
        end else begin
            rst_done_reg <= 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_accept) begin
                        adr_reg       <= cmd_adr_i;
                        dat_reg       <= cmd_dat_i;
                        we_reg        <= cmd_we_i;
                        retry_cnt_reg <= '0;
                        tmo_cnt_reg   <= '0;
                    end
                end
                ST_CYCLE: begin
                    if (wb_err_i) begin
                        status_reg <= STATUS_ERR;
                    end else if (wb_rty_i) begin
                        if (retry_left) begin
                            retry_cnt_reg <= retry_cnt_reg + 1'b1;
                            tmo_cnt_reg   <= '0;
                        end else begin
                            status_reg <= STATUS_RETRY_EXH;
                        end
                    end else if (wb_ack_i) begin
                        rsp_dat_reg <= wb_dat_i;
                        status_reg  <= STATUS_OK;
                    end else if (tmo_hit) begin
                        status_reg <= STATUS_TIMEOUT;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_coeff_master.sv
// Self-checking bench for wb_coeff_master: directed vector table, random
// transactions against a per-attempt reference model, and reset corner cases.
module tb_wb_coeff_master;

    localparam int ADR_W     = 22;
    localparam int DAT_W     = 32;
    localparam int TIMEOUT   = 255;
    localparam int MAX_RETRY = 3;

    localparam logic [1:0] K_ACK  = 2'd0;  // ack only
    localparam logic [1:0] K_ERR  = 2'd1;  // err and ack together
    localparam logic [1:0] K_RTY  = 2'd2;  // rty and ack together
    localparam logic [1:0] K_NONE = 2'd3;  // never terminate

    typedef struct {
        logic             we;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
        logic [DAT_W-1:0] rdata;
        logic [3:0][1:0]  kind;
        logic [3:0][7:0]  dly;
        int               hold;
        logic [1:0]       exp_status;
        int               exp_attempts;
        int               exp_cyc;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cmd_valid, cmd_ready, cmd_we;
    logic [ADR_W-1:0]   cmd_adr;
    logic [DAT_W-1:0]   cmd_dat;
    logic               rsp_valid, rsp_ready;
    logic [DAT_W-1:0]   rsp_dat;
    logic [1:0]         rsp_status;
    logic               wb_cyc, wb_stb, wb_we;
    logic [ADR_W-1:0]   wb_adr;
    logic [DAT_W-1:0]   wb_dat_o;
    logic [DAT_W/8-1:0] wb_sel;
    logic               wb_ack, wb_err, wb_rty;
    logic [DAT_W-1:0]   wb_dat_i;
    logic               busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_coeff_master #(
        .ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .wb_clk_i(clk),        .wb_rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_adr_i(cmd_adr),   .cmd_dat_i(cmd_dat),   .cmd_we_i(cmd_we),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_dat_o(rsp_dat),   .rsp_status_o(rsp_status),
        .wb_cyc_o(wb_cyc),     .wb_stb_o(wb_stb),     .wb_we_o(wb_we),
        .wb_adr_o(wb_adr),     .wb_dat_o(wb_dat_o),   .wb_sel_o(wb_sel),
        .wb_ack_i(wb_ack),     .wb_err_i(wb_err),     .wb_rty_i(wb_rty),
        .wb_dat_i(wb_dat_i),   .busy_o(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic we, input logic [ADR_W-1:0] adr,
                                 input logic [DAT_W-1:0] dat, input logic [DAT_W-1:0] rdata,
                                 input logic [1:0] k0, input logic [7:0] d0,
                                 input logic [1:0] k1, input logic [7:0] d1,
                                 input logic [1:0] k2, input logic [7:0] d2,
                                 input logic [1:0] k3, input logic [7:0] d3,
                                 input int hold, input logic [1:0] est,
                                 input int eatt, input int ecyc);
        vec_t v;
        v.we = we; v.adr = adr; v.dat = dat; v.rdata = rdata;
        v.kind[0] = k0; v.dly[0] = d0;
        v.kind[1] = k1; v.dly[1] = d1;
        v.kind[2] = k2; v.dly[2] = d2;
        v.kind[3] = k3; v.dly[3] = d3;
        v.hold = hold; v.exp_status = est; v.exp_attempts = eatt; v.exp_cyc = ecyc;
        return v;
    endfunction

    // Reference: walk the scripted attempts and apply the termination rules.
    function automatic vec_t model(input vec_t vin);
        vec_t v = vin;
        int   cyc = 0;
        v.exp_attempts = 0;
        v.exp_status   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            v.exp_attempts = i + 1;
            if (v.kind[i] == K_NONE || int'(v.dly[i]) >= TIMEOUT) begin
                cyc += TIMEOUT;
                v.exp_status = 2'd2;
                break;
            end
            cyc += int'(v.dly[i]) + 1;
            if (v.kind[i] == K_ERR) begin
                v.exp_status = 2'd1;
                break;
            end
            if (v.kind[i] == K_ACK) begin
                v.exp_status = 2'd0;
                break;
            end
            if (i == MAX_RETRY) begin
                v.exp_status = 2'd3;
                break;
            end
        end
        v.exp_cyc = cyc;
        return v;
    endfunction

    task automatic clear_slave();
        wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 10 && !cmd_ready; i++) begin
            @(posedge clk); #1;
        end
        check("cmd_ready_wait", cmd_ready, 1'b1);
    endtask

    task automatic run_txn(input vec_t v, input int id);
        int  attempts = 0, hi = 0, cyc_total = 0, gaps = 0;
        logic prev_cyc = 1'b0;
        wait_ready();
        cmd_valid = 1'b1; cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            clear_slave();
            wb_dat_i = $urandom;
            check("stb_without_cyc", wb_stb & ~wb_cyc, 1'b0);
            if (rsp_valid) break;
            if (wb_cyc) begin
                if (!prev_cyc) begin
                    attempts++;
                    hi = 0;
                    check("bus_adr", wb_adr, v.adr);
                    check("bus_dat", wb_dat_o, v.dat);
                    check("bus_we", wb_we, v.we);
                    check("bus_sel", wb_sel, 4'hF);
                    check("busy_cycle", busy, 1'b1);
                end
                cyc_total++;
                if (attempts <= 4 && v.kind[attempts-1] != K_NONE &&
                    hi == int'(v.dly[attempts-1])) begin
                    wb_dat_i = v.rdata;
                    wb_ack   = 1'b1;
                    wb_err   = (v.kind[attempts-1] == K_ERR);
                    wb_rty   = (v.kind[attempts-1] == K_RTY);
                end
                hi++;
            end else if (attempts > 0) begin
                gaps++;
            end
            prev_cyc = wb_cyc;
            @(posedge clk); #1;
        end
        check("rsp_seen", rsp_valid, 1'b1);
        check("rsp_status", rsp_status, v.exp_status);
        check("attempts", attempts, v.exp_attempts);
        check("cyc_cycles", cyc_total, v.exp_cyc);
        check("backoff_gaps", gaps, v.exp_attempts - 1);
        if (v.exp_status == 2'd0) check("rsp_dat", rsp_dat, v.rdata);
        // Hold off the consumer while the target chatters; response must not move.
        for (int i = 0; i < v.hold; i++) begin
            wb_ack = 1'($urandom_range(0, 1));
            wb_err = 1'($urandom_range(0, 1));
            wb_rty = 1'($urandom_range(0, 1));
            wb_dat_i = $urandom;
            @(posedge clk); #1;
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_cyc", wb_cyc, 1'b0);
            check("hold_status", rsp_status, v.exp_status);
            if (v.exp_status == 2'd0) check("hold_dat", rsp_dat, v.rdata);
        end
        clear_slave();
        rsp_ready = 1'b1;
        check("ready_in_resp", cmd_ready, 1'b0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("busy_after", busy, 1'b0);
        check("valid_after", rsp_valid, 1'b0);
        check("ready_after", cmd_ready, 1'b1);
        $display("txn %0d: we=%0d adr=0x%06h status=%0d attempts=%0d cyc=%0d",
                 id, v.we, v.adr, rsp_status, attempts, cyc_total);
    endtask

    vec_t tbl[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        tbl[0] = mkv(1'b1, 22'h000084, 32'h0000_1234, 32'h0,
                     K_ACK, 8'd2, K_ACK, 8'd0, K_ACK, 8'd0, K_ACK, 8'd0, 0, 2'd0, 1, 3);
        tbl[1] = mkv(1'b0, 22'h000004, 32'h0, 32'hDEADBEEF,
                     K_ACK, 8'd0, K_ACK, 8'd0, K_ACK, 8'd0, K_ACK, 8'd0, 6, 2'd0, 1, 1);
        tbl[2] = mkv(1'b0, 22'h000010, 32'h0, 32'hCAFE0001,
                     K_RTY, 8'd1, K_RTY, 8'd0, K_ACK, 8'd3, K_ACK, 8'd0, 1, 2'd0, 3, 7);
        tbl[3] = mkv(1'b1, 22'h000020, 32'h5555AAAA, 32'h0,
                     K_RTY, 8'd0, K_RTY, 8'd0, K_RTY, 8'd0, K_RTY, 8'd0, 2, 2'd3, 4, 4);
        tbl[4] = mkv(1'b0, 22'h3FFFFC, 32'h0, 32'h0,
                     K_NONE, 8'd0, K_ACK, 8'd0, K_ACK, 8'd0, K_ACK, 8'd0, 0, 2'd2, 1, 255);
        tbl[5] = mkv(1'b0, 22'h000030, 32'h0, 32'h12345678,
                     K_ERR, 8'd1, K_ACK, 8'd0, K_ACK, 8'd0, K_ACK, 8'd0, 3, 2'd1, 1, 2);
        tbl[6] = mkv(1'b0, 22'h000040, 32'h0, 32'h0BADF00D,
                     K_ACK, 8'd254, K_ACK, 8'd0, K_ACK, 8'd0, K_ACK, 8'd0, 0, 2'd0, 1, 255);
        tbl[7] = mkv(1'b1, 22'h000050, 32'h87654321, 32'h0,
                     K_RTY, 8'd0, K_NONE, 8'd0, K_ACK, 8'd0, K_ACK, 8'd0, 0, 2'd2, 2, 256);

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        rsp_ready = 1'b0; wb_dat_i = '0; clear_slave();
        repeat (3) @(posedge clk);
        #1;
        check("rst_cyc", wb_cyc, 1'b0);
        check("rst_stb", wb_stb, 1'b0);
        check("rst_we", wb_we, 1'b0);
        check("rst_adr", wb_adr, '0);
        check("rst_dat", wb_dat_o, '0);
        check("rst_sel", wb_sel, '0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_dat", rsp_dat, '0);
        check("rst_rsp_status", rsp_status, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_release", cmd_ready, 1'b1);

        for (int i = 0; i < 8; i++) run_txn(tbl[i], i);

        // Reset in the middle of a bus cycle: cyc drops at once, no response.
        wait_ready();
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 22'h000100;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("mid_cyc_high", wb_cyc, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_cyc", wb_cyc, 1'b0);
        check("mid_rst_stb", wb_stb, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_valid", rsp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("post_rst_valid", rsp_valid, 1'b0);
        check("post_rst_cyc", wb_cyc, 1'b0);
        check("post_rst_ready", cmd_ready, 1'b1);
        run_txn(tbl[1], 100);

        for (int i = 0; i < 30; i++) begin
            v.we = 1'($urandom_range(0, 1));
            v.adr = ADR_W'($urandom);
            v.dat = $urandom;
            v.rdata = $urandom;
            for (int a = 0; a < 4; a++) begin
                int r = $urandom_range(0, 19);
                v.kind[a] = (r < 9) ? K_ACK : (r < 11) ? K_ERR : (r < 19) ? K_RTY : K_NONE;
                v.dly[a] = 8'($urandom_range(0, 6));
            end
            v.hold = $urandom_range(0, 4);
            v = model(v);
            run_txn(v, 200 + i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
